// File: rtl/mat_pkg.sv
// Shared widths and sequencer state encoding for the 4x4 double-precision matrix add path.
package mat_pkg;
    localparam int ELEM_W    = 64;
    localparam int MAT_ELEMS = 16;
    localparam int MAT_W     = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;
endpackage

// File: rtl/mat4add_seq.sv
// Streams one 4x4 matrix add through a LANES-wide mat4add datapath, chunk by chunk,
// and reassembles the result for a valid/ready consumer.
module mat4add_seq
    import mat_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [MAT_W-1:0]        mat_a,
    input  logic [MAT_W-1:0]        mat_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [MAT_W-1:0]        mat_c,
    output logic                    err,
    output logic [ELEM_W*LANES-1:0] dp_a,
    output logic [ELEM_W*LANES-1:0] dp_b,
    output logic                    dp_valid,
    output logic                    dp_start,
    input  logic [ELEM_W*LANES-1:0] dp_c,
    input  logic                    dp_done,
    output logic                    dp_output_read
);
    localparam int CHUNK_W = ELEM_W * LANES;
    localparam int NCHUNK  = MAT_ELEMS / LANES;
    localparam int K_W     = 4;
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    logic [K_W-1:0]         r_k;
    logic [WD_W-1:0]        r_wd;
    logic                   r_err;
    logic                   r_dp_go;
    logic                   r_dp_or;
    logic [MAT_W-1:0]       r_a;
    logic [MAT_W-1:0]       r_b;
    logic [MAT_W-1:0]       r_c;
    logic [CHUNK_W-1:0]     r_dp_a;
    logic [CHUNK_W-1:0]     r_dp_b;
    logic                   w_accept;
    logic                   w_last;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_k == K_W'(NCHUNK - 1));

    // Operand capture carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= mat_a;
            r_b <= mat_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            r_dp_go <= 1'b0;
            r_dp_or <= 1'b0;
            r_c     <= '0;
            r_dp_a  <= '0;
            r_dp_b  <= '0;
        end else begin
            r_dp_go <= 1'b0;
            r_dp_or <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_k     <= '0;
                        r_wd    <= '0;
                        r_c     <= '0;
                        r_dp_a  <= mat_a[0 +: CHUNK_W];
                        r_dp_b  <= mat_b[0 +: CHUNK_W];
                        r_dp_go <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        r_c[int'(r_k)*CHUNK_W +: CHUNK_W] <= dp_c;
                        r_dp_or <= 1'b1;
                        r_state <= DRAIN;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                DRAIN: begin
                    // A done still high from this chunk must not be mistaken for the next one.
                    if (!dp_done) begin
                        if (w_last) begin
                            r_state <= OUT;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_dp_a  <= r_a[(int'(r_k) + 1)*CHUNK_W +: CHUNK_W];
                            r_dp_b  <= r_b[(int'(r_k) + 1)*CHUNK_W +: CHUNK_W];
                            r_dp_go <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == IDLE);
    assign res_valid      = (r_state == OUT);
    assign mat_c          = r_c;
    assign err            = r_err;
    assign dp_a           = r_dp_a;
    assign dp_b           = r_dp_b;
    assign dp_valid       = r_dp_go;
    assign dp_start       = r_dp_go;
    assign dp_output_read = r_dp_or;
endmodule

// File: tb/tb_mat4add_seq.sv
// Bench for mat4add_seq: three instances (LANES 2/1/4) each paired with a behavioural datapath stub.
module tb_mat4add_seq;
    import mat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              res_ready = 1'b1;
    logic [MAT_W-1:0]  mat_a = '0;
    logic [MAT_W-1:0]  mat_b = '0;

    int stub_d      = 5;
    int stub_hold   = 0;
    bit stub_nodone = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    function automatic logic [MAT_W-1:0] madd(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*64 +: 64] = dadd(a[i*64 +: 64], b[i*64 +: 64]);
        return r;
    endfunction

    function automatic logic [MAT_W-1:0] build(input real base, input real step);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*64 +: 64] = $realtobits(base + step * i);
        return r;
    endfunction

    task automatic cmp_mat(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        int idx;
        idx = 0;
        for (int i = 15; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
        chk(act === exp, $sformatf("%s[%0d]", name, idx), act[idx*64 +: 64], exp[idx*64 +: 64]);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L   = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        localparam int NCH = 16 / L;

        logic             req_ready, res_valid, err, dp_valid, dp_start, dp_done, dp_or;
        logic [MAT_W-1:0] mat_c;
        logic [64*L-1:0]  dp_a, dp_b, dp_c, s_sum;
        logic             rst_ok;

        mat4add_seq #(.LANES(L), .TIMEOUT(16)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready),
            .mat_a(mat_a), .mat_b(mat_b),
            .res_valid(res_valid), .res_ready(res_ready),
            .mat_c(mat_c), .err(err),
            .dp_a(dp_a), .dp_b(dp_b),
            .dp_valid(dp_valid), .dp_start(dp_start),
            .dp_c(dp_c), .dp_done(dp_done),
            .dp_output_read(dp_or)
        );

        assign rst_ok = req_ready && !res_valid && !dp_valid && !dp_start && !dp_or && !err &&
                        (mat_c == '0) && (dp_a == '0) && (dp_b == '0);

        always_comb begin
            s_sum = '0;
            for (int j = 0; j < L; j++) s_sum[j*64 +: 64] = dadd(dp_a[j*64 +: 64], dp_b[j*64 +: 64]);
        end

        // Datapath stub: done D cycles after start, drops (1+hold) cycles after output_read.
        int s_cnt;
        int s_drop;
        bit s_busy;
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                dp_done <= 1'b0;
                dp_c    <= '0;
                s_cnt   <= 0;
                s_drop  <= 0;
                s_busy  <= 1'b0;
            end else begin
                if (dp_start) begin
                    s_cnt  <= 1;
                    s_busy <= !stub_nodone && (stub_d > 1);
                    if (!stub_nodone && stub_d == 1) begin
                        dp_done <= 1'b1;
                        dp_c    <= s_sum;
                    end
                end else if (s_busy) begin
                    if (s_cnt == stub_d - 1) begin
                        dp_done <= 1'b1;
                        dp_c    <= s_sum;
                        s_busy  <= 1'b0;
                    end else begin
                        s_cnt <= s_cnt + 1;
                    end
                end
                if (dp_or) begin
                    s_drop <= stub_hold;
                    if (stub_hold == 0) dp_done <= 1'b0;
                end else if (s_drop > 0) begin
                    s_drop <= s_drop - 1;
                    if (s_drop == 1) dp_done <= 1'b0;
                end
            end
        end

        // Reference model: expected result and arrival cycle per accepted request.
        logic [MAT_W-1:0] expq[$];
        int               accq[$];
        int               latq[$];
        int               cyc      = 0;
        int               starts   = 0;
        int               last_lat = 0;
        bit               prev_rv  = 1'b0;

        always @(negedge clk) begin
            if (!rst) begin
                expq.delete();
                accq.delete();
                latq.delete();
                prev_rv = 1'b0;
                starts  = 0;
            end else begin
                cyc++;
                if (dp_start) starts++;
                if (res_valid) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, $sformatf("L%0d unexpected_res_valid", L), 64'(res_valid), 64'd0);
                    end else begin
                        if (!prev_rv) begin
                            last_lat = cyc - accq[0];
                            chk(last_lat == latq[0], $sformatf("L%0d latency", L), 64'(last_lat), 64'(latq[0]));
                            chk(starts == NCH, $sformatf("L%0d start_pulses", L), 64'(starts), 64'(NCH));
                        end
                        cmp_mat($sformatf("L%0d mat_c", L), mat_c, expq[0]);
                        chk(req_ready == 1'b0, $sformatf("L%0d req_ready_in_out", L), 64'(req_ready), 64'd0);
                        if (res_ready) begin
                            void'(expq.pop_front());
                            void'(accq.pop_front());
                            void'(latq.pop_front());
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    if (!stub_nodone) begin
                        expq.push_back(madd(mat_a, mat_b));
                        accq.push_back(cyc);
                        latq.push_back(NCH * (stub_d + 3 + stub_hold) + 1);
                    end
                    starts = 0;
                end
                prev_rv = res_valid;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(g_inst[0].req_ready && g_inst[1].req_ready && g_inst[2].req_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 2000, "idle_wait_bound", 64'(n), 64'd2000);
    endtask

    task automatic send(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        wait_idle();
        req_valid = 1'b1;
        mat_a     = a;
        mat_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rv0(output int n);
        n = 0;
        while (!g_inst[0].res_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 500, "res_valid_wait_bound", 64'(n), 64'd500);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0t, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int n;
        logic [MAT_W-1:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        chk(g_inst[0].rst_ok, "reset_L2", 64'(g_inst[0].rst_ok), 64'd1);
        chk(g_inst[1].rst_ok, "reset_L1", 64'(g_inst[1].rst_ok), 64'd1);
        chk(g_inst[2].rst_ok, "reset_L4", 64'(g_inst[2].rst_ok), 64'd1);
        chk(g_inst[0].req_ready == 1'b1, "reset_req_ready", 64'(g_inst[0].req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // 1.0 + 2.0 everywhere, D=5
        send(build(1.0, 0.0), build(2.0, 0.0));
        wait_rv0(n);
        chk(n + 1 == 65, "latency_literal_L2", 64'(n + 1), 64'd65);
        chk(g_inst[0].mat_c[0 +: 64] == 64'h4008000000000000, "three_elem0", g_inst[0].mat_c[0 +: 64], 64'h4008000000000000);
        chk(g_inst[0].mat_c[960 +: 64] == 64'h4008000000000000, "three_elem15", g_inst[0].mat_c[960 +: 64], 64'h4008000000000000);
        wait_idle();

        // element ordering: A[i]=i, B[i]=100*i
        send(build(0.0, 1.0), build(0.0, 100.0));
        wait_rv0(n);
        chk(g_inst[0].mat_c[320 +: 64] == 64'h407F900000000000, "order_elem5", g_inst[0].mat_c[320 +: 64], 64'h407F900000000000);
        wait_idle();

        // stale done held one extra cycle
        stub_hold = 1;
        send(build(-3.5, 0.25), build(10.0, -1.5));
        wait_idle();
        stub_hold = 0;
        stub_d    = 3;
        send(build(7.0, 2.0), build(0.125, 0.5));
        wait_idle();
        stub_d = 5;

        // back-pressure
        res_ready = 1'b0;
        send(build(1.5, 1.0), build(2.5, -2.0));
        n = 0;
        while (!(g_inst[0].res_valid && g_inst[1].res_valid && g_inst[2].res_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 500, "bp_wait_bound", 64'(n), 64'd500);
        repeat (20) @(posedge clk);
        #1;
        chk(g_inst[0].res_valid == 1'b1, "bp_res_valid_held", 64'(g_inst[0].res_valid), 64'd1);
        chk(g_inst[0].req_ready == 1'b0, "bp_req_ready_low", 64'(g_inst[0].req_ready), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk(g_inst[0].req_ready == 1'b1, "bp_idle_after_accept", 64'(g_inst[0].req_ready), 64'd1);
        chk(g_inst[0].res_valid == 1'b0, "bp_res_valid_drop", 64'(g_inst[0].res_valid), 64'd0);
        send(build(4.0, 4.0), build(-1.0, 3.0));
        wait_idle();

        // watchdog timeout
        stub_nodone = 1'b1;
        send(build(9.0, 1.0), build(9.0, 1.0));
        repeat (16) @(posedge clk);
        #1;
        chk(g_inst[0].err == 1'b0, "timeout_err_not_early", 64'(g_inst[0].err), 64'd0);
        @(posedge clk); #1;
        chk(g_inst[0].err == 1'b1, "timeout_err_L2", 64'(g_inst[0].err), 64'd1);
        chk(g_inst[1].err == 1'b1, "timeout_err_L1", 64'(g_inst[1].err), 64'd1);
        chk(g_inst[2].err == 1'b1, "timeout_err_L4", 64'(g_inst[2].err), 64'd1);
        chk(g_inst[0].req_ready == 1'b1, "timeout_idle", 64'(g_inst[0].req_ready), 64'd1);
        stub_nodone = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // err is sticky while new requests still complete
        send(build(0.5, 0.5), build(0.25, 0.75));
        wait_idle();
        chk(g_inst[0].err == 1'b1, "err_sticky", 64'(g_inst[0].err), 64'd1);

        // reset during chunk 3
        a = build(0.5, 1.0);
        b = build(8.0, -2.0);
        send(a, b);
        repeat (26) @(posedge clk);
        #1;
        chk(g_inst[0].dp_a == a[6*64 +: 128], "chunk3_dp_a", g_inst[0].dp_a[127:64], a[7*64 +: 64]);
        #2;
        rst = 1'b0;
        #1;
        chk(g_inst[0].rst_ok, "midreset_L2", 64'(g_inst[0].rst_ok), 64'd1);
        chk(g_inst[1].rst_ok, "midreset_L1", 64'(g_inst[1].rst_ok), 64'd1);
        chk(g_inst[2].rst_ok, "midreset_L4", 64'(g_inst[2].rst_ok), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        send(build(-6.0, 0.5), build(6.0, 0.5));
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
